// File: rtl/wb_stream_pkg.sv
// Shared Wishbone cycle-type encodings, fetch FSM states and burst sizing helper
// for the stream fetch controller.
package wb_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_BURST      = 2'd2
    } fetch_state_e;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_INC_BURST    = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;
    localparam logic [1:0] BTE_LINEAR       = 2'b00;

    // Words in the next burst: the configured length (0 means 1), capped by what is left.
    function automatic logic [7:0] burst_words(input logic [7:0] blen, input logic [31:0] rem);
        logic [7:0] eff;
        eff = (blen == 8'd0) ? 8'd1 : blen;
        return (rem < {24'd0, eff}) ? rem[7:0] : eff;
    endfunction

endpackage

// File: rtl/wb_stream_fetch_ctrl.sv
// Reads a word buffer over Wishbone incrementing bursts, sized to fit the downstream
// FIFO, and forwards every acked word straight onto the stream output.
module wb_stream_fetch_ctrl
    import wb_stream_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic [WB_AW-1:0]   start_adr_i,
    input  logic [31:0]        buf_size_i,
    input  logic [7:0]         burst_len_i,
    input  logic [FIFO_AW:0]   fifo_cnt_i,
    output logic [WB_AW-1:0]   wbm_adr_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic [WB_DW-1:0]   stream_m_data_o,
    output logic               stream_m_valid_o,
    input  logic               stream_m_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               ovf_o
);

    // Wide enough that fill + burst length cannot wrap before the compare.
    localparam int CW = (FIFO_AW + 2 > 10) ? FIFO_AW + 2 : 10;
    localparam logic [CW-1:0] FIFO_DEPTH = CW'(1) << FIFO_AW;

    fetch_state_e     state_q, state_d;
    logic             enable_q;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [31:0]      rem_q, rem_d;
    logic [7:0]       blen_q, blen_d;
    logic [7:0]       beat_q, beat_d;
    logic             abort_q, abort_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;

    logic             start_edge;
    logic             space_ok;
    logic             last_beat;
    logic [7:0]       next_words;

    assign start_edge = enable_i & ~enable_q;
    assign next_words = burst_words(blen_q, rem_q);
    assign space_ok   = (CW'(fifo_cnt_i) + CW'(next_words)) <= FIFO_DEPTH;
    assign last_beat  = (beat_q == 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            enable_q <= 1'b0;
            adr_q    <= '0;
            rem_q    <= '0;
            blen_q   <= '0;
            beat_q   <= '0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_i;
            adr_q    <= adr_d;
            rem_q    <= rem_d;
            blen_q   <= blen_d;
            beat_q   <= beat_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        adr_d            = adr_q;
        rem_d            = rem_q;
        blen_d           = blen_q;
        beat_d           = beat_q;
        abort_d          = abort_q;
        done_d           = 1'b0;
        err_d            = err_q;
        ovf_d            = ovf_q;
        wbm_cyc_o        = 1'b0;
        wbm_stb_o        = 1'b0;
        wbm_cti_o        = CTI_CLASSIC;
        stream_m_valid_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    err_d = 1'b0;
                    ovf_d = 1'b0;
                    if (buf_size_i != 32'd0) begin
                        state_d = ST_WAIT_SPACE;
                        adr_d   = start_adr_i;
                        rem_d   = buf_size_i;
                        blen_d  = burst_len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_WAIT_SPACE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (space_ok) begin
                    state_d = ST_BURST;
                    beat_d  = next_words;
                    abort_d = 1'b0;
                end
            end

            ST_BURST: begin
                wbm_cyc_o        = 1'b1;
                wbm_stb_o        = 1'b1;
                wbm_cti_o        = last_beat ? CTI_END_OF_BURST : CTI_INC_BURST;
                stream_m_valid_o = wbm_ack_i;
                // A dropped enable lets the burst in flight finish before stopping.
                abort_d          = abort_q | ~enable_i;
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (wbm_ack_i) begin
                    adr_d  = adr_q + WB_AW'(4);
                    rem_d  = rem_q - 32'd1;
                    beat_d = beat_q - 8'd1;
                    if (!stream_m_ready_i) begin
                        ovf_d = 1'b1;
                    end
                    if (last_beat) begin
                        if (abort_d) begin
                            state_d = ST_IDLE;
                        end else if (rem_q == 32'd1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT_SPACE;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign wbm_adr_o       = adr_q;
    assign wbm_sel_o       = '1;
    assign wbm_we_o        = 1'b0;
    assign wbm_bte_o       = BTE_LINEAR;
    assign stream_m_data_o = wbm_dat_i;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_wb_stream_fetch_ctrl.sv
// Bench for wb_stream_fetch_ctrl: a random Wishbone slave plus a beat-list model of
// each transfer, checked every cycle, with a few literal expectations on directed cases.
module tb_wb_stream_fetch_ctrl;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int FAW   = 4;
    localparam int FCW   = FAW + 1;
    localparam int DEPTH = 1 << FAW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [AW-1:0]  start_adr = '0;
    logic [31:0]    buf_size = '0;
    logic [7:0]     burst_len = '0;
    logic [FCW-1:0] fifo_cnt;
    logic [FCW-1:0] fifo_fixed = '0;
    logic [FCW-1:0] fifo_rnd = '0;
    bit             fifo_rand = 1'b0;
    logic [AW-1:0]  wbm_adr;
    logic [DW-1:0]  wbm_dat = '0;
    logic [DW/8-1:0] wbm_sel;
    logic           wbm_we, wbm_cyc, wbm_stb;
    logic [2:0]     wbm_cti;
    logic [1:0]     wbm_bte;
    logic           ack_r = 1'b0, err_r = 1'b0;
    logic           wbm_ack, wbm_err;
    logic [DW-1:0]  s_data;
    logic           s_valid;
    logic           s_ready = 1'b1;
    logic           busy, done, err, ovf;

    assign wbm_ack  = ack_r & wbm_cyc;
    assign wbm_err  = err_r & wbm_cyc;
    assign fifo_cnt = fifo_rand ? fifo_rnd : fifo_fixed;

    wb_stream_fetch_ctrl #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .start_adr_i(start_adr),
        .buf_size_i(buf_size), .burst_len_i(burst_len), .fifo_cnt_i(fifo_cnt),
        .wbm_adr_o(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err),
        .stream_m_data_o(s_data), .stream_m_valid_o(s_valid), .stream_m_ready_i(s_ready),
        .busy_o(busy), .done_o(done), .err_o(err), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // Slave and environment controls
    int ack_pct = 100;
    int ready_pct = 100;
    int err_beat = -1;

    // Model: the list of beats still owed by the current transfer
    typedef struct packed {
        logic [31:0] adr;
        logic        last;
    } beat_t;
    beat_t mq[$];
    bit    m_active, m_burst, m_abort, m_done, m_err, m_ovf, m_en_prev;
    int    acc_beats = 0;

    logic [31:0] log_adr[$];
    logic [2:0]  log_cti[$];
    int          done_cnt = 0;
    int          cyc_cycles = 0;

    function automatic int next_burst_len();
        int n = 0;
        for (int i = 0; i < mq.size(); i++) begin
            n++;
            if (mq[i].last) break;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        #1;
        wbm_dat  = $urandom;
        s_ready  = ($urandom_range(0, 99) < ready_pct);
        fifo_rnd = FCW'($urandom_range(0, DEPTH));
        err_r    = wbm_cyc && (err_beat >= 0) && (acc_beats == err_beat);
        ack_r    = wbm_cyc && !err_r && ($urandom_range(0, 99) < ack_pct);
    end

    always @(negedge clk) begin
        bit    edge_seen;
        int    blen_eff;
        beat_t b;
        if (wbm_cyc) cyc_cycles++;
        if (done) done_cnt++;
        if (wbm_ack && wbm_cyc) begin
            log_adr.push_back(wbm_adr);
            log_cti.push_back(wbm_cti);
        end
        if (rst) begin
            chk("rst_cyc", wbm_cyc, 0);
            chk("rst_stb", wbm_stb, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_adr", wbm_adr, 0);
            chk("rst_cti", wbm_cti, 0);
            chk("rst_bte", wbm_bte, 0);
            chk("rst_sel", wbm_sel, 4'hF);
            mq.delete();
            m_active = 0; m_burst = 0; m_abort = 0; m_done = 0;
            m_err = 0; m_ovf = 0; m_en_prev = 0;
        end else begin
            chk("busy", busy, m_active);
            chk("cyc", wbm_cyc, m_burst);
            chk("stb", wbm_stb, m_burst);
            chk("we", wbm_we, 0);
            chk("sel", wbm_sel, 4'hF);
            chk("bte", wbm_bte, 0);
            chk("valid", s_valid, m_burst & wbm_ack);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("ovf", ovf, m_ovf);
            if (m_burst && mq.size() > 0) begin
                chk("adr", wbm_adr, mq[0].adr);
                chk("cti", wbm_cti, mq[0].last ? 3'b111 : 3'b010);
            end
            if (s_valid) chk("data", s_data, wbm_dat);

            m_done = 0;
            edge_seen = enable && !m_en_prev;
            if (!m_active) begin
                if (edge_seen) begin
                    m_err = 0;
                    m_ovf = 0;
                    if (buf_size == 0) begin
                        m_done = 1;
                    end else begin
                        blen_eff = (burst_len == 0) ? 1 : int'(burst_len);
                        for (int k = 0; k < int'(buf_size); k++) begin
                            b.adr  = start_adr + 32'(4 * k);
                            b.last = ((k % blen_eff) == blen_eff - 1) || (k == int'(buf_size) - 1);
                            mq.push_back(b);
                        end
                        m_active  = 1;
                        m_burst   = 0;
                        acc_beats = 0;
                    end
                end
            end else if (!m_burst) begin
                if (!enable) begin
                    m_active = 0;
                    mq.delete();
                end else if (DEPTH - int'(fifo_cnt) >= next_burst_len()) begin
                    m_burst = 1;
                    m_abort = 0;
                end
            end else begin
                if (!enable) m_abort = 1;
                if (wbm_err) begin
                    m_err = 1; m_active = 0; m_burst = 0;
                    mq.delete();
                end else if (wbm_ack) begin
                    b = mq.pop_front();
                    acc_beats++;
                    if (!s_ready) m_ovf = 1;
                    if (b.last) begin
                        m_burst = 0;
                        if (m_abort) begin
                            m_active = 0;
                            mq.delete();
                        end else if (mq.size() == 0) begin
                            m_active = 0;
                            m_done = 1;
                        end
                    end
                end
            end
            m_en_prev = enable;
        end
    end

    task automatic start_xfer(input logic [31:0] a, input int n, input int bl);
        @(posedge clk); #1;
        log_adr.delete();
        log_cti.delete();
        done_cnt   = 0;
        cyc_cycles = 0;
        start_adr  = a;
        buf_size   = 32'(n);
        burst_len  = 8'(bl);
        enable     = 1'b1;
    endtask

    task automatic wait_idle(input int abort_after);
        int cnt;
        cnt = 0;
        while (cnt < 2 || m_active) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == abort_after) enable = 1'b0;
            if (cnt >= 3000) begin
                checks++;
                failures++;
                $display("FAIL timeout t=%0t busy after %0d cycles, expected idle", $time, cnt);
                break;
            end
        end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Two 4-beat bursts
        start_xfer(32'h1000, 8, 4);
        wait_idle(0);
        chk("t1_beats", log_adr.size(), 8);
        chk("t1_adr0", log_adr[0], 32'h1000);
        chk("t1_adr4", log_adr[4], 32'h1010);
        chk("t1_adr7", log_adr[7], 32'h101C);
        chk("t1_cti0", log_cti[0], 3'b010);
        chk("t1_cti2", log_cti[2], 3'b010);
        chk("t1_cti3", log_cti[3], 3'b111);
        chk("t1_cti4", log_cti[4], 3'b010);
        chk("t1_cti7", log_cti[7], 3'b111);
        chk("t1_done", done_cnt, 1);

        // Not enough FIFO space until the fill drops to 12
        fifo_fixed = 14;
        start_xfer(32'h2000, 4, 4);
        repeat (8) @(posedge clk);
        #1;
        chk("t2_hold_cyc", cyc_cycles, 0);
        chk("t2_hold_busy", busy, 1);
        fifo_fixed = 12;
        chk("t2_cyc_before", wbm_cyc, 0);
        @(posedge clk); #1;
        chk("t2_cyc_after", wbm_cyc, 1);
        wait_idle(0);
        fifo_fixed = 0;
        chk("t2_beats", log_adr.size(), 4);

        // Short tail burst
        start_xfer(32'h3000, 5, 4);
        wait_idle(0);
        chk("t3_beats", log_adr.size(), 5);
        chk("t3_cti3", log_cti[3], 3'b111);
        chk("t3_adr4", log_adr[4], 32'h3010);
        chk("t3_cti4", log_cti[4], 3'b111);
        chk("t3_done", done_cnt, 1);

        // Bus error on beat 2
        err_beat = 1;
        start_xfer(32'h4000, 4, 4);
        wait_idle(0);
        err_beat = -1;
        chk("t4_err", err, 1);
        chk("t4_busy", busy, 0);
        chk("t4_cyc", wbm_cyc, 0);
        chk("t4_done", done_cnt, 0);
        chk("t4_beats", log_adr.size(), 1);

        // Reset during beat 3, then a fresh start
        start_xfer(32'h5000, 8, 4);
        n = 0;
        while (log_adr.size() < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_beat3_cyc", wbm_cyc, 1);
        chk("t5_beat3_adr", wbm_adr, 32'h5008);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_cyc", wbm_cyc, 0);
        chk("t5_rst_stb", wbm_stb, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_adr", wbm_adr, 0);
        chk("t5_rst_cti", wbm_cti, 0);
        chk("t5_rst_valid", s_valid, 0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc_cycles = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_no_resume", cyc_cycles, 0);
        chk("t5_idle_busy", busy, 0);
        start_xfer(32'h6000, 2, 4);
        wait_idle(0);
        chk("t5_restart_adr", log_adr[0], 32'h6000);
        chk("t5_restart_beats", log_adr.size(), 2);
        chk("t5_restart_done", done_cnt, 1);

        // Stream not ready: overflow flagged, transfer still completes
        ready_pct = 0;
        start_xfer(32'h7000, 4, 4);
        wait_idle(0);
        ready_pct = 100;
        chk("t6_ovf", ovf, 1);
        chk("t6_beats", log_adr.size(), 4);
        chk("t6_done", done_cnt, 1);

        // Zero-length start and zero burst length
        start_xfer(32'h8000, 0, 4);
        wait_idle(0);
        chk("t7_done", done_cnt, 1);
        chk("t7_cyc", cyc_cycles, 0);
        start_xfer(32'h9000, 3, 0);
        wait_idle(0);
        chk("t8_beats", log_adr.size(), 3);
        chk("t8_cti0", log_cti[0], 3'b111);
        chk("t8_cti1", log_cti[1], 3'b111);

        // Randomized transfers: address wrap, flaky ack/ready/space, errors, aborts
        fifo_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int sz, bl, ab;
            a  = (t == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            sz = (t == 0) ? 4 : int'($urandom_range(0, 20));
            bl = int'($urandom_range(0, 8));
            ack_pct   = int'($urandom_range(40, 100));
            ready_pct = int'($urandom_range(60, 100));
            err_beat  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            ab        = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 12)) : 0;
            start_xfer(a, sz, bl);
            wait_idle(ab);
        end
        err_beat  = -1;
        fifo_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t simulation did not finish, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
